// File: rtl/cr_prefix_fe_cmp_chain.sv
// Prefix feature-extractor compare chain: NUM_CMP chained compare cells on one byte stream,
// with per-frame hit counting and first-hit position of the last cell.
module cr_prefix_fe_cmp_chain #(
  parameter int unsigned NUM_CMP = 4,
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHAR_W-1:0]         char_in,
  input  logic                      char_valid,
  input  logic                      char_sof,
  input  logic                      char_eof,
  output logic                      char_ready,
  input  logic [NUM_CMP-1:0]        cfg_use_prior,
  input  logic [NUM_CMP-1:0]        cfg_no_delay,
  input  logic [NUM_CMP*CHAR_W-1:0] cfg_match_val,
  input  logic [NUM_CMP*2-1:0]      cfg_cmp_type,
  output logic [NUM_CMP-1:0]        hit_vec,
  output logic                      hit_valid,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [CNT_W-1:0]          result_cnt,
  output logic [CNT_W-1:0]          result_first_pos,
  output logic                      result_hit_any,
  output logic                      err_sof
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StActive, StFlush, StReport} state_e;

  state_e                      state_q, state_d;
  logic [NUM_CMP-1:0]          use_prior_q, no_delay_q, cmp_q, cmp_d, hd_q;
  logic [NUM_CMP*CHAR_W-1:0]   match_q;
  logic [NUM_CMP*2-1:0]        type_q;
  logic                        valid_q, err_q;
  logic [CNT_W-1:0]            idx_q, pos_q, cnt_q, first_q, cur_idx;
  logic                        accept, take, restart, drop, abort;

  function automatic logic cmp_fn(input logic [CHAR_W-1:0] c, input logic [CHAR_W-1:0] v,
                                  input logic [1:0] t);
    unique case (t)
      2'd0:    return c == v;
      2'd1:    return c != v;
      2'd2:    return c > v;
      default: return c < v;
    endcase
  endfunction

  assign char_ready = (state_q == StIdle) || (state_q == StActive);
  assign accept     = char_valid && char_ready;
  assign restart    = accept && char_sof;
  // Characters outside a frame are dropped; only frame characters enter the pipeline.
  assign take       = accept && (char_sof || (state_q != StIdle));
  assign drop       = accept && !char_sof && (state_q == StIdle);
  assign abort      = restart && (state_q == StActive);
  assign cur_idx    = char_sof ? '0 : idx_q;

  // The sof character is compared against the incoming config, which becomes active with it.
  always_comb begin
    cmp_d = '0;
    for (int unsigned i = 0; i < NUM_CMP; i++) begin
      cmp_d[i] = restart ? cmp_fn(char_in, cfg_match_val[i*CHAR_W +: CHAR_W], cfg_cmp_type[2*i +: 2])
                         : cmp_fn(char_in, match_q[i*CHAR_W +: CHAR_W], type_q[2*i +: 2]);
    end
  end

  always_comb begin
    logic prev, prior, h;
    hit_vec = '0;
    prev    = 1'b0;
    for (int unsigned i = 0; i < NUM_CMP; i++) begin
      prior = 1'b0;
      if (i > 0) prior = no_delay_q[i] ? prev : hd_q[i-1];
      h = cmp_q[i];
      if (use_prior_q[i]) h = (type_q[2*i +: 2] == 2'd0) ? (prior | cmp_q[i]) : (prior & cmp_q[i]);
      hit_vec[i] = valid_q & h;
      prev = h;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (restart) state_d = char_eof ? StFlush : StActive;
      StActive: if (accept && char_eof) state_d = StFlush;
      StFlush:  state_d = StReport;
      default:  if (result_ready) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      use_prior_q <= '0;
      no_delay_q  <= '0;
      match_q     <= '0;
      type_q      <= '0;
      cmp_q       <= '0;
      hd_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      pos_q       <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= take;
      err_q   <= drop | abort;
      if (restart) begin
        use_prior_q <= cfg_use_prior;
        no_delay_q  <= cfg_no_delay;
        match_q     <= cfg_match_val;
        type_q      <= cfg_cmp_type;
      end
      if (take) begin
        cmp_q <= cmp_d;
        pos_q <= cur_idx;
        idx_q <= (cur_idx == CntMax) ? CntMax : cur_idx + 1'b1;
      end
      // A new frame wins over the trailing hit of an aborted one.
      if (restart) begin
        hd_q    <= '0;
        cnt_q   <= '0;
        first_q <= CntMax;
      end else if (valid_q) begin
        hd_q <= hit_vec;
        if (hit_vec[NUM_CMP-1]) begin
          if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '0) first_q <= pos_q;
        end
      end
    end
  end

  assign hit_valid        = valid_q;
  assign result_valid     = (state_q == StReport);
  assign result_cnt       = cnt_q;
  assign result_first_pos = first_q;
  assign result_hit_any   = (cnt_q != '0);
  assign err_sof          = err_q;

endmodule

// File: tb/tb_cr_prefix_fe_cmp_chain.sv
// Randomized scoreboard bench for cr_prefix_fe_cmp_chain against a frame-level reference model.
module tb_cr_prefix_fe_cmp_chain;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int MAXV = (1 << NW) - 1;

  typedef struct {
    int cnt;
    int first;
    bit any;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CW-1:0]   char_in = '0;
  logic            char_valid = 1'b0, char_sof = 1'b0, char_eof = 1'b0;
  logic            char_ready;
  logic [N-1:0]    cfg_use_prior = '0, cfg_no_delay = '0;
  logic [N*CW-1:0] cfg_match_val = '0;
  logic [N*2-1:0]  cfg_cmp_type = '0;
  logic [N-1:0]    hit_vec;
  logic            hit_valid, result_valid, result_hit_any, err_sof;
  logic            result_ready = 1'b0;
  logic [NW-1:0]   result_cnt, result_first_pos;

  int checks = 0, errors = 0;
  int err_exp = 0, err_seen = 0;
  bit rr_rand = 1'b0, rr_force = 1'b0;
  logic [N-1:0]    hv_q[$];
  res_t            res_q[$];

  // Frame configuration applied together with the sof character.
  logic [N-1:0]    f_up, f_nd;
  logic [N*CW-1:0] f_val;
  logic [N*2-1:0]  f_typ;

  cr_prefix_fe_cmp_chain #(.NUM_CMP(N), .CHAR_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid), .char_sof(char_sof),
    .char_eof(char_eof), .char_ready(char_ready), .cfg_use_prior(cfg_use_prior),
    .cfg_no_delay(cfg_no_delay), .cfg_match_val(cfg_match_val), .cfg_cmp_type(cfg_cmp_type),
    .hit_vec(hit_vec), .hit_valid(hit_valid), .result_valid(result_valid),
    .result_ready(result_ready), .result_cnt(result_cnt), .result_first_pos(result_first_pos),
    .result_hit_any(result_hit_any), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    result_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_force;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference: evaluate the whole frame from the cell rules, character by character.
  task automatic model_frame(input logic [CW-1:0] chars[$], input bit report_it);
    logic [N-1:0] prev_hv, cur;
    int cnt, first;
    bit c, prior;
    int t, v, ch;
    prev_hv = '0;
    cnt = 0;
    first = MAXV;
    for (int k = 0; k < chars.size(); k++) begin
      cur = '0;
      ch = int'(chars[k]);
      for (int i = 0; i < N; i++) begin
        t = int'(f_typ[2*i +: 2]);
        v = int'(f_val[i*CW +: CW]);
        c = (t == 0) ? (ch == v) : (t == 1) ? (ch != v) : (t == 2) ? (ch > v) : (ch < v);
        prior = (i == 0) ? 1'b0 : (f_nd[i] ? cur[i-1] : prev_hv[i-1]);
        cur[i] = !f_up[i] ? c : (t == 0) ? (prior | c) : (prior & c);
      end
      hv_q.push_back(cur);
      if (cur[N-1]) begin
        if (cnt == 0) first = (k > MAXV) ? MAXV : k;
        cnt = (cnt == MAXV) ? MAXV : cnt + 1;
      end
      prev_hv = cur;
    end
    if (report_it) res_q.push_back('{cnt: cnt, first: first, any: cnt != 0});
  endtask

  task automatic send(input logic [CW-1:0] c, input bit sof, input bit eof);
    int n = 0;
    @(negedge clk);
    if (sof) begin
      cfg_use_prior = f_up; cfg_no_delay = f_nd; cfg_match_val = f_val; cfg_cmp_type = f_typ;
    end else begin
      // Config changes inside a frame must not reach the active cells.
      cfg_use_prior = N'($urandom); cfg_no_delay = N'($urandom);
      cfg_match_val = {$urandom}; cfg_cmp_type = 8'($urandom);
    end
    char_in = c; char_sof = sof; char_eof = eof; char_valid = 1'b1;
    while (!char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("char_ready_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      char_valid = 1'b0; char_sof = 1'b0; char_eof = 1'b0;
    end
  endtask

  function automatic logic [CW-1:0] pick_val();
    case ($urandom_range(0, 3))
      0: return 8'h61;
      1: return 8'h62;
      2: return 8'h63;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rand_cfg();
    f_up = N'($urandom); f_nd = N'($urandom); f_typ = 8'($urandom);
    for (int i = 0; i < N; i++) f_val[i*CW +: CW] = pick_val();
  endtask

  task automatic run_frame(input int len, input bit report_it, input bit gaps,
                           input logic [CW-1:0] fill, input bit use_fill);
    logic [CW-1:0] chars[$];
    for (int k = 0; k < len; k++) begin
      if (use_fill) chars.push_back(fill);
      else chars.push_back(($urandom_range(0, 3) != 0) ? 8'(8'h61 + $urandom_range(0, 3))
                                                        : 8'($urandom));
    end
    model_frame(chars, report_it);
    for (int k = 0; k < len; k++) begin
      send(chars[k], k == 0, report_it && (k == len - 1));
      if (gaps && k != len - 1 && $urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic check_reset_state();
    chk("rst_char_ready", int'(char_ready), 1);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_hit_vec", int'(hit_vec), 0);
    chk("rst_err_sof", int'(err_sof), 0);
    chk("rst_result_cnt", int'(result_cnt), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents hits or a result.
  bit   prev_stall = 1'b0;
  res_t prev_res;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (hit_valid) begin
        if (hv_q.size() == 0) chk("hit_unexpected", 1, 0);
        else chk("hit_vec", int'(hit_vec), int'(hv_q.pop_front()));
      end else if (hit_vec != '0) begin
        chk("hit_vec_idle", int'(hit_vec), 0);
      end
      if (err_sof) err_seen++;
      if (prev_stall) begin
        chk("stall_valid", int'(result_valid), 1);
        chk("stall_cnt", int'(result_cnt), prev_res.cnt);
        chk("stall_first", int'(result_first_pos), prev_res.first);
      end
      prev_stall = 1'b0;
      if (result_valid) begin
        chk("ready_in_report", int'(char_ready), 0);
        prev_res = '{cnt: int'(result_cnt), first: int'(result_first_pos), any: result_hit_any};
        if (result_ready) begin
          if (res_q.size() == 0) begin
            chk("result_unexpected", 1, 0);
          end else begin
            res_t e;
            e = res_q.pop_front();
            chk("result_cnt", int'(result_cnt), e.cnt);
            chk("result_first_pos", int'(result_first_pos), e.first);
            chk("result_hit_any", int'(result_hit_any), int'(e.any));
          end
        end else begin
          prev_stall = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Single-char frame: result one cycle after FLUSH, then held while unacknowledged.
    f_up = '0; f_nd = '0; f_typ = '0; f_val = {4{8'h61}};
    run_frame(1, 1'b1, 1'b0, 8'h61, 1'b1);
    @(posedge clk);
    idle(1);
    chk("lat_flush_no_result", int'(result_valid), 0);
    idle(1);
    chk("lat_report_result", int'(result_valid), 1);
    idle(5);
    rr_rand = 1'b1;
    // Non-matching single char: no hit, first_pos all-ones.
    f_val = {4{8'h7a}};
    run_frame(1, 1'b1, 1'b0, 8'h61, 1'b1);
    // Char without sof while idle is dropped.
    send(8'h61, 1'b0, 1'b0);
    err_exp++;
    idle(2);
    // Counter saturation.
    f_val = {4{8'h61}};
    run_frame(20, 1'b1, 1'b0, 8'h61, 1'b1);

    for (int f = 0; f < 60; f++) begin
      rand_cfg();
      case ($urandom_range(0, 5))
        0: begin
          run_frame($urandom_range(1, 5), 1'b0, 1'b1, 8'h0, 1'b0);
          err_exp++;
          rand_cfg();
          run_frame($urandom_range(1, 8), 1'b1, 1'b1, 8'h0, 1'b0);
        end
        1: begin
          run_frame($urandom_range(2, 5), 1'b1, 1'b1, 8'h0, 1'b0);
          send(8'($urandom), 1'b0, 1'b0);
          err_exp++;
        end
        default: run_frame($urandom_range(1, 18), 1'b1, 1'b1, 8'h0, 1'b0);
      endcase
      idle($urandom_range(0, 2));
    end

    // Reset mid-frame discards the frame.
    rand_cfg();
    run_frame(3, 1'b0, 1'b0, 8'h0, 1'b0);
    idle(3);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("post_reset_no_result", int'(result_valid), 0);
    rand_cfg();
    run_frame(6, 1'b1, 1'b1, 8'h0, 1'b0);
    idle(1);

    n = 0;
    while ((hv_q.size() != 0 || res_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_hits_left", hv_q.size(), 0);
    chk("drain_results_left", res_q.size(), 0);
    idle(3);
    chk("err_sof_pulses", err_seen, err_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
